// File: rtl/bus_mem_responder_if.sv
// Tagged request/response bus between the core's arbiter (master) and the
// memory responder (slave).
interface bus_mem_responder_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
) ();
  logic                      reqcyc;
  logic                      reqack;
  logic [BUS_DATA_WIDTH-1:0] req;
  logic [BUS_TAG_WIDTH-1:0]  reqtag;
  logic                      respcyc;
  logic                      respack;
  logic [BUS_DATA_WIDTH-1:0] resp;
  logic [BUS_TAG_WIDTH-1:0]  resptag;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-side responder: accepts line writes into a word array and returns
// line reads as tagged bursts after a fixed latency.
module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8,
  parameter int MEM_WORDS      = 4096,
  parameter int LATENCY        = 4
) (
  input  logic                clk,
  input  logic                reset,
  bus_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = $clog2(BEATS);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] RD_RESP = 2'd3;

  logic [1:0]                state_reg, state_next;
  logic                      reqack_reg;
  logic                      respcyc_reg;
  logic [BUS_DATA_WIDTH-1:0] resp_reg;
  logic [BUS_TAG_WIDTH-1:0]  resptag_reg;
  logic [BUS_TAG_WIDTH-1:0]  tag_reg;
  logic [AW-BW-1:0]          line_reg;
  logic [BW-1:0]             beat_reg;
  logic [LW-1:0]             lat_reg;

  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic          req_fire, resp_fire, lat_done, last_beat;
  logic          wr_en, rd_en;
  logic [BW-1:0] rd_beat;
  logic [AW-1:0] wr_addr, rd_addr;

  assign req_fire  = bus.reqcyc & reqack_reg;
  assign resp_fire = respcyc_reg & bus.respack;
  assign lat_done  = (lat_reg == LW'(LATENCY - 1));
  assign last_beat = (beat_reg == BW'(BEATS - 1));

  assign bus.reqack  = reqack_reg;
  assign bus.respcyc = respcyc_reg;
  assign bus.resp    = resp_reg;
  assign bus.resptag = resptag_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_fire) state_next = bus.reqtag[BUS_TAG_WIDTH-1] ? WR_DATA : RD_WAIT;
      WR_DATA: if (req_fire && last_beat) state_next = IDLE;
      RD_WAIT: if (lat_done) state_next = RD_RESP;
      RD_RESP: if (resp_fire && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The read port is the response register itself: it loads beat 0 as the
  // latency expires and the following beat on each accepted transfer, so a
  // stalled beat simply holds.
  assign rd_beat = (state_reg == RD_WAIT) ? '0 : beat_reg + BW'(1);
  assign rd_addr = {line_reg, rd_beat};
  assign rd_en   = ((state_reg == RD_WAIT) && lat_done) ||
                   ((state_reg == RD_RESP) && resp_fire && !last_beat);
  assign wr_addr = {line_reg, beat_reg};
  assign wr_en   = (state_reg == WR_DATA) && req_fire;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_reg <= '0;
    end else if (rd_en) begin
      resp_reg <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      reqack_reg  <= 1'b0;
      respcyc_reg <= 1'b0;
      resptag_reg <= '0;
      tag_reg     <= '0;
      line_reg    <= '0;
      beat_reg    <= '0;
      lat_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      reqack_reg <= (state_next == IDLE) || (state_next == WR_DATA);
      case (state_reg)
        IDLE: begin
          if (req_fire) begin
            line_reg <= bus.req[3+BW +: AW-BW];
            tag_reg  <= bus.reqtag;
            beat_reg <= '0;
            lat_reg  <= '0;
          end
        end
        WR_DATA: begin
          if (req_fire) beat_reg <= beat_reg + BW'(1);
        end
        RD_WAIT: begin
          lat_reg <= lat_reg + LW'(1);
          if (lat_done) begin
            respcyc_reg <= 1'b1;
            resptag_reg <= tag_reg;
            beat_reg    <= '0;
          end
        end
        RD_RESP: begin
          if (resp_fire) begin
            if (last_beat) respcyc_reg <= 1'b0;
            else           beat_reg    <= beat_reg + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: table of write/read transactions
// with a response scoreboard, plus reset sequences.
module tb_bus_mem_responder;
  localparam int DW        = 64;
  localparam int TW        = 13;
  localparam int BEATS     = 8;
  localparam int MEM_WORDS = 4096;
  localparam int LATENCY   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_mem_responder_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus_if ();

  bus_mem_responder #(
    .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS),
    .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [12:0] tag;
    logic [63:0] d0;          // write data of beat 0, or expected read data of beat 0
    int          stall_beat;  // read: beat held with respack low
    int          stall_n;
    int          gap_beat;    // write: reqcyc low after this data beat
    int          gap_n;
  } vec_t;

  vec_t vecs[9];
  logic [76:0] sb[$];  // {tag, data} expected per read beat
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a posedge; returns just after the transfer edge.
  task automatic send(input logic [63:0] d, input logic [12:0] t, input logic must_ready);
    int n = 0;
    bus_if.reqcyc = 1'b1;
    bus_if.req    = d;
    bus_if.reqtag = t;
    @(negedge clk);
    if (must_ready) chk("reqack_ready", 64'(bus_if.reqack), 64'd1);
    while (!bus_if.reqack && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!must_ready) chk("reqack_wait", 64'(bus_if.reqack), 64'd1);
    @(posedge clk);
    #1;
    last_cyc = cyc;
    bus_if.reqcyc = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] d0,
                          input int gap_beat, input int gap_n);
    send(addr, tag, 1'b1);
    for (int i = 0; i < BEATS; i++) begin
      send(d0 + 64'(i), 13'h0000, 1'b1);  // tag ignored on data transfers
      if (i == gap_beat) begin
        repeat (gap_n) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] exp0,
                         input int stall_beat, input int stall_n, input int abort_beat);
    int beat = 0;
    int stalls = stall_n;
    int guard = 0;
    int hdr;
    logic [76:0] e;
    for (int i = 0; i < BEATS; i++) sb.push_back({tag, exp0 + 64'(i)});
    bus_if.respack = 1'b1;
    send(addr, tag, 1'b1);
    hdr = last_cyc;
    @(negedge clk);
    while (!bus_if.respcyc && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("rd_latency", 64'(cyc - hdr), 64'(LATENCY));
    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      e = sb[0];
      chk("respcyc_burst", 64'(bus_if.respcyc), 64'd1);
      chk("resp_data", bus_if.resp, e[63:0]);
      chk("resp_tag", 64'(bus_if.resptag), 64'(e[76:64]));
      if (beat == abort_beat) begin
        reset = 1'b1;
        bus_if.respack = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_respcyc", 64'(bus_if.respcyc), 64'd0);
        chk("abort_reqack_in_reset", 64'(bus_if.reqack), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_reqack_after", 64'(bus_if.reqack), 64'd1);
        chk("abort_respcyc_after", 64'(bus_if.respcyc), 64'd0);
        bus_if.respack = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      if (beat == stall_beat && stalls > 0) begin
        bus_if.respack = 1'b0;
        stalls--;
      end else begin
        bus_if.respack = 1'b1;
        void'(sb.pop_front());
        beat++;
      end
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      chk("rd_beats_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    chk("rd_end_respcyc", 64'(bus_if.respcyc), 64'd0);
    chk("rd_end_reqack", 64'(bus_if.reqack), 64'd1);
    bus_if.respack = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 64'h1000,         13'h1005, 64'hA0, -1, 0, -1, 0};
    vecs[1] = '{1'b0, 64'h1000,         13'h0042, 64'hA0, -1, 0, -1, 0};
    vecs[2] = '{1'b0, 64'h1000,         13'h0042, 64'hA0,  2, 3, -1, 0};
    vecs[3] = '{1'b0, 64'h1018,         13'h0007, 64'hA0, -1, 0, -1, 0};
    vecs[4] = '{1'b0, 64'h1000 + 32768, 13'h0011, 64'hA0, -1, 0, -1, 0};
    vecs[5] = '{1'b1, 64'h2000,         13'h1001, 64'hB0, -1, 0,  3, 2};
    vecs[6] = '{1'b1, 64'h2040,         13'h1FFF, 64'hC0, -1, 0, -1, 0};
    vecs[7] = '{1'b0, 64'h2000,         13'h0100, 64'hB0, -1, 0, -1, 0};
    vecs[8] = '{1'b0, 64'h2040,         13'h0FFF, 64'hC0,  0, 1, -1, 0};

    // Reset with a pending read header on the bus.
    reset = 1'b1;
    bus_if.reqcyc  = 1'b1;
    bus_if.req     = 64'h1000;
    bus_if.reqtag  = 13'h0001;
    bus_if.respack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      if (i == 2) begin
        #1;
        reset = 1'b0;
      end
      @(negedge clk);
      chk("rst_reqack", 64'(bus_if.reqack), 64'd0);
      chk("rst_respcyc", 64'(bus_if.respcyc), 64'd0);
      chk("rst_resp", bus_if.resp, 64'd0);
      chk("rst_resptag", 64'(bus_if.resptag), 64'd0);
    end
    @(negedge clk);
    chk("rst_reqack_after", 64'(bus_if.reqack), 64'd1);
    bus_if.reqcyc = 1'b0;
    @(posedge clk);
    #1;
    $display("reset: done");

    for (int v = 0; v < 9; v++) begin
      $display("vec %0d: %s addr=%h tag=%h d0=%h", v, vecs[v].wr ? "write" : "read ",
               vecs[v].addr, vecs[v].tag, vecs[v].d0);
      if (vecs[v].wr)
        do_write(vecs[v].addr, vecs[v].tag, vecs[v].d0, vecs[v].gap_beat, vecs[v].gap_n);
      else
        do_read(vecs[v].addr, vecs[v].tag, vecs[v].d0, vecs[v].stall_beat, vecs[v].stall_n, -1);
    end

    // Reset while beat 5 of a read is presented, then a full re-read.
    $display("seq: read 0x2000 aborted by reset at beat 5");
    do_read(64'h2000, 13'h0005, 64'hB0, -1, 0, 5);
    $display("seq: read 0x2000 after abort");
    do_read(64'h2000, 13'h0006, 64'hB0, -1, 0, -1);
    $display("seq: read 0x1000 after abort");
    do_read(64'h1000, 13'h0ABC, 64'hA0, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side end of the core's tagged request/response bus: the slave and responder for the bus master that the core's arbiter drives.
- Accepts line-sized read and write transactions and stores the data in an internal word array.
- Returns read data as a burst of tagged beats after a programmable latency.
- Used as the simulation and FPGA backing store behind the core's bus port.

Parameters:
- BUS_DATA_WIDTH, 64: width of req/resp data, in bits.
- BUS_TAG_WIDTH, 13: width of req/resp tag. Bit [BUS_TAG_WIDTH-1] is the write flag (1=write, 0=read).
- BEATS, 8: data beats per transaction. Power of 2, so a line is BEATS*8 bytes.
- MEM_WORDS, 4096: depth of the internal array in 64-bit words. Power of 2, and at least BEATS.
- LATENCY, 4: cycles from read acceptance to the first response beat. Must be at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-high.
- bus_reqcyc  in  1  request valid, driven by the master.
- bus_reqack  out  1  request ready. A transfer occurs on a posedge where bus_reqcyc=1 and bus_reqack=1.
- bus_req  in  BUS_DATA_WIDTH  carries the byte address in the header transfer and the write data in data transfers.
- bus_reqtag  in  BUS_TAG_WIDTH  header tag. Ignored on write-data transfers.
- bus_respcyc  out  1  response beat valid.
- bus_respack  in  1  master ready. A beat transfers on a posedge where bus_respcyc=1 and bus_respack=1.
- bus_resp  out  BUS_DATA_WIDTH  read data beat.
- bus_resptag  out  BUS_TAG_WIDTH  tag of the read transaction, echoed unchanged.

Behaviour:
- All outputs are registered.
- During and immediately after reset: bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, state=IDLE.
- Reset does not clear the array.
- Address mapping:
  - idx = bus_req[3 +: log2(MEM_WORDS)]. Higher address bits are ignored, so addresses alias modulo MEM_WORDS*8 bytes.
  - Line base = idx with the low log2(BEATS) bits cleared.
  - Beat i accesses base+i, for i = 0..BEATS-1 in ascending order.
  - Unaligned addresses are truncated to the line base.
- States: IDLE, WR_DATA, RD_WAIT, RD_RESP.
- IDLE:
  - bus_reqack=1.
  - On a header transfer: latch line base and bus_reqtag.
  - Tag MSB=1: go to WR_DATA with beat count 0, reqack staying 1.
  - Tag MSB=0: go to RD_WAIT; reqack=0 from the next cycle.
- WR_DATA:
  - bus_reqack=1.
  - Each transfer writes bus_req to array[base+count] and increments count.
  - After beat BEATS-1 is transferred: go to IDLE. Back-to-back headers are legal with no idle cycle.
  - Cycles with bus_reqcyc=0 are wait states and do not advance the count.
  - Writes produce no response.
- RD_WAIT:
  - bus_reqack=0.
  - A counter runs for LATENCY cycles.
  - For a header accepted at edge N, bus_respcyc is high from just after edge N+LATENCY.
  - Go to RD_RESP, presenting beat 0 with bus_resptag = the latched tag.
- RD_RESP:
  - bus_reqack=0.
  - While bus_respcyc=1 and bus_respack=0, bus_resp and bus_resptag hold stable.
  - On each beat transfer, present the next beat in the following cycle; there are no bubbles between beats.
  - After beat BEATS-1 is transferred: bus_respcyc=0 and go to IDLE; reqack=1 from the next cycle.
  - The next header can therefore be accepted no earlier than 1 cycle after the last beat.
- Read-after-write: a read of a line sees all beats of every write completed before its header was accepted.
- Reset mid-transaction:
  - Return to IDLE and drop bus_respcyc on the next cycle.
  - Write beats already transferred remain in the array.
  - Remaining beats are abandoned and no response is produced.
- Simultaneous events: bus_reqcyc arriving in a state where bus_reqack=0 is not accepted. The master must hold it, and it is accepted once the block is back in IDLE.
- Concurrency: only one transaction is in flight at a time.

Test Plan:
- Reset check: assert reset for 3 cycles with bus_reqcyc=1 -> during reset and the first cycle after: reqack=0, respcyc=0, resp=0, resptag=0. reqack=1 the cycle after.
- Write then read:
  - Write header addr 0x1000, tag 0x1005, then 8 data beats 0xA0..0xA7 -> reqack=1 throughout.
  - Read header addr 0x1000, tag 0x0042 accepted at edge N -> respcyc rises after edge N+4, beats 0xA0..0xA7 in order, resptag=0x0042 on every beat.
- Response stall: same read with respack low for 3 cycles on beat 2 -> resp=0xA2 held stable for 4 cycles, 8 beats total, no beat lost or duplicated.
- Unaligned and alias:
  - Read at 0x1018 -> returns line 0x1000 starting with 0xA0.
  - Read at 0x1000 + 4096*8 -> identical data.
- Write-data wait states and back-to-back writes: reqcyc low for 2 cycles between write beats 3 and 4, then a second write header the cycle after beat 7 -> both lines are written correctly, verified by readback.
- Reset mid-read: assert reset during beat 5 of a read -> respcyc=0 the next cycle, reqack=1 one cycle after reset is released, and a subsequent read of the same line returns the full, correct data.
